serial_adder_ctrl: RTL

Bit-serial N-bit adder controller that drives a single external one-bit full-adder cell, one bit per clock. It loads two operands and a carry-in on START and presents operand bits LSB-first to the cell with the registered carry. It collects the cell's SUM into a result shift register and feeds its C_OUT back as the next carry. It reports sum, carry-out and signed overflow with a one-cycle DONE pulse.

---
 rtl/serial_adder_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: streams operand bits LSB-first through an external
// one-bit full-adder cell and collects the sum, carry-out and signed overflow.
module serial_adder_ctrl #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             c_in_i,
    output logic             fa_a_o,
    output logic             fa_b_o,
    output logic             fa_cin_o,
    input  logic             fa_sum_i,
    input  logic             fa_cout_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] sum_out_o,
    output logic             c_out_o,
    output logic             ovf_o
);

    localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(Width - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q;
    logic [Width-1:0] a_sh_q;
    logic [Width-1:0] b_sh_q;
    logic [Width-1:0] res_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;

    // Result word as it stands once the current bit's SUM is shifted in.
    logic [Width-1:0] res_next;
    assign res_next = {fa_sum_i, res_q[Width-1:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        carry_q <= c_in_i;
                        cnt_q   <= '0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= fa_cout_i;
                    res_q   <= res_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        sum_q   <= res_next;
                        cout_q  <= fa_cout_i;
                        // Carry into the MSB differs from carry out of it on signed overflow.
                        ovf_q   <= carry_q ^ fa_cout_i;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o    = (state_q == StShift);
    assign fa_a_o    = busy_o & a_sh_q[0];
    assign fa_b_o    = busy_o & b_sh_q[0];
    assign fa_cin_o  = busy_o & carry_q;
    assign done_o    = done_q;
    assign sum_out_o = sum_q;
    assign c_out_o   = cout_q;
    assign ovf_o     = ovf_q;

endmodule
